// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Serial pattern detector with a run-time loadable N-bit pattern, selectable
//   overlapping / non-overlapping matching and a saturating match counter.
//
//   state table (progress k = number of leading pattern bits matched)
//     k         | meaning
//     0         | searching, nothing matched
//     1 .. N-1  | partial match of the first k pattern bits
//     N         | match; o_out = 1 while here
//
// Ports
//   i_clk   : clock, all updates on rising edge
//   i_rst   : synchronous active-high reset (pattern <= PATTERN, k, out, cnt <= 0)
//   i_en    : bit-valid, i_in consumed only when high
//   i_in    : serial input bit
//   i_ovl   : 1 = overlapping matches, 0 = non-overlapping
//   i_load  : load i_pat as the active pattern, restart search
//   i_pat   : new pattern, MSB is the first bit expected
//   i_clr   : clear the match counter
//   o_out   : registered match flag (k == N)
//   o_cnt   : registered saturating match count
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int              N       = 4,
    parameter logic [N-1:0]    PATTERN = 4'b1011,
    parameter int              CW      = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_in,
    input  logic          i_ovl,
    input  logic          i_load,
    input  logic [N-1:0]  i_pat,
    input  logic          i_clr,
    output logic          o_out,
    output logic [CW-1:0] o_cnt
);

    localparam int            KW      = $clog2(N + 1);
    localparam logic [KW-1:0] K_MATCH = KW'(N);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [N-1:0]  r_pr;
    logic [KW-1:0] r_k;
    logic          r_out;
    logic [CW-1:0] r_cnt;

    logic [KW-1:0] w_border;
    logic [KW-1:0] w_kp;
    logic [KW-1:0] w_k_next;
    logic          w_hit;

    // Bit of pr at position pos, done with a shift to keep index widths clean.
    function automatic logic f_bit(input logic [N-1:0] pr, input int pos);
        logic [N-1:0] t;
        t = pr >> pos;
        return t[0];
    endfunction

    // Longest proper prefix of pr that is also a suffix of pr.
    function automatic logic [KW-1:0] f_border(input logic [N-1:0] pr);
        logic [KW-1:0] best;
        logic          ok;
        best = '0;
        for (int j = 1; j < N; j++) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i < j) begin
                    if (f_bit(pr, N - 1 - i) != f_bit(pr, j - 1 - i)) ok = 1'b0;
                end
            end
            if (ok) best = KW'(j);
        end
        return best;
    endfunction

    // Candidate string s = first kp pattern bits followed by b (length kp+1).
    // Result is the longest pattern prefix that is a suffix of s.
    function automatic logic [KW-1:0] f_next_k(input logic [N-1:0] pr,
                                               input logic [KW-1:0] kp,
                                               input logic b);
        logic [KW-1:0] best;
        logic          ok;
        logic          sb;
        int            len;
        int            idx;
        best = '0;
        len  = int'(kp) + 1;
        for (int j = 1; j <= N; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (i < j) begin
                        idx = len - j + i;
                        sb  = (idx == int'(kp)) ? b : f_bit(pr, N - 1 - idx);
                        if (f_bit(pr, N - 1 - i) != sb) ok = 1'b0;
                    end
                end
                if (ok) best = KW'(j);
            end
        end
        return best;
    endfunction

    always_comb begin
        w_border = f_border(r_pr);
        // From the match state the search resumes at the border (overlap) or
        // from scratch, so no bit of a completed match is reused.
        if (r_k == K_MATCH) begin
            w_kp = i_ovl ? w_border : '0;
        end else begin
            w_kp = r_k;
        end
        w_k_next = f_next_k(r_pr, w_kp, i_in);
        w_hit    = (w_k_next == K_MATCH);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pr  <= PATTERN;
            r_k   <= '0;
            r_out <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (i_load) begin
                r_pr  <= i_pat;
                r_k   <= '0;
                r_out <= 1'b0;
            end else if (i_en) begin
                r_k   <= w_k_next;
                r_out <= w_hit;
            end

            if (i_clr) begin
                r_cnt <= '0;
            end else if (!i_load && i_en && w_hit && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_out = r_out;
    assign o_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int N = 4;
    localparam logic [N-1:0] PAT0 = 4'b1011;

    logic         clk;
    logic         t_rst, t_en, t_in, t_ovl, t_load, t_clr;
    logic [N-1:0] t_pat;
    logic         out8, out2;
    logic [7:0]   cnt8;
    logic [1:0]   cnt2;

    int errs   = 0;
    int checks = 0;

    // reference model state
    logic [N-1:0] mpr;
    bit           hist[$];
    bit           mmatch;
    int           mcnt8, mcnt2;
    bit           armed = 0;

    seq_detect_param #(.N(N), .PATTERN(PAT0), .CW(8)) u_dut8 (
        .i_clk(clk), .i_rst(t_rst), .i_en(t_en), .i_in(t_in), .i_ovl(t_ovl),
        .i_load(t_load), .i_pat(t_pat), .i_clr(t_clr), .o_out(out8), .o_cnt(cnt8));

    seq_detect_param #(.N(N), .PATTERN(PAT0), .CW(2)) u_dut2 (
        .i_clk(clk), .i_rst(t_rst), .i_en(t_en), .i_in(t_in), .i_ovl(t_ovl),
        .i_load(t_load), .i_pat(t_pat), .i_clr(t_clr), .o_out(out2), .o_cnt(cnt2));

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: a match is the last N consumed bits equalling the pattern.
    // Non-overlap mode forgets history right after a match.
    always @(posedge clk) begin
        bit hit;
        bit eq;
        hit = 0;
        if (t_rst) begin
            mpr = PAT0;
            hist.delete();
            mmatch = 0;
            mcnt8 = 0;
            mcnt2 = 0;
            armed = 1;
        end else begin
            if (t_load) begin
                mpr = t_pat;
                hist.delete();
                mmatch = 0;
            end else if (t_en) begin
                if (mmatch && !t_ovl) hist.delete();
                hist.push_back(t_in);
                if (hist.size() > N) void'(hist.pop_front());
                eq = (hist.size() == N);
                if (eq) begin
                    for (int i = 0; i < N; i++)
                        if (hist[i] != mpr[N-1-i]) eq = 0;
                end
                mmatch = eq;
                hit = eq;
            end
            if (t_clr) begin
                mcnt8 = 0;
                mcnt2 = 0;
            end else if (hit) begin
                if (mcnt8 < 255) mcnt8++;
                if (mcnt2 < 3) mcnt2++;
            end
        end
    end

    // Single compare process against the model, every cycle after reset.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (out8 !== mmatch || out2 !== mmatch) begin
                errs++;
                $display("FAIL out_model t=%0t got out8=%b out2=%b want %b", $time, out8, out2, mmatch);
            end
            checks++;
            if (cnt8 !== 8'(mcnt8) || cnt2 !== 2'(mcnt2)) begin
                errs++;
                $display("FAIL cnt_model t=%0t got cnt8=%0d cnt2=%0d want %0d/%0d", $time, cnt8, cnt2, mcnt8, mcnt2);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic in, input logic ovl, input logic load,
                        input logic [N-1:0] pat, input logic clr, input logic rst);
        t_en = en; t_in = in; t_ovl = ovl; t_load = load; t_pat = pat; t_clr = clr; t_rst = rst;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic bitin(input logic b, input logic ovl);
        step(1, b, ovl, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, '0, 0, 1);
    endtask

    initial begin
        t_rst = 0; t_en = 0; t_in = 0; t_ovl = 0; t_load = 0; t_pat = '0; t_clr = 0;
        @(negedge clk); #1;

        do_reset();
        chk("reset_out", int'(out8), 0);
        chk("reset_cnt", int'(cnt8), 0);

        // 1011011, non-overlapping
        bitin(1, 0); bitin(0, 0); bitin(1, 0);
        chk("nonovl_bit3_out", int'(out8), 0);
        bitin(1, 0);
        chk("nonovl_bit4_out", int'(out8), 1);
        bitin(0, 0); bitin(1, 0); bitin(1, 0);
        chk("nonovl_bit7_out", int'(out8), 0);
        chk("nonovl_cnt", int'(cnt8), 1);

        // same stream, overlapping
        do_reset();
        bitin(1, 1); bitin(0, 1); bitin(1, 1); bitin(1, 1);
        chk("ovl_bit4_out", int'(out8), 1);
        bitin(0, 1); bitin(1, 1); bitin(1, 1);
        chk("ovl_bit7_out", int'(out8), 1);
        chk("ovl_cnt", int'(cnt8), 2);

        // reset mid-sequence
        do_reset();
        bitin(1, 0); bitin(0, 0); bitin(1, 0);
        do_reset();
        bitin(1, 0);
        chk("rstmid_out", int'(out8), 0);
        chk("rstmid_cnt", int'(cnt8), 0);
        bitin(0, 0); bitin(1, 0); bitin(1, 0);
        chk("rstmid_after_out", int'(out8), 1);
        chk("rstmid_after_cnt", int'(cnt8), 1);

        // idle cycles hold state
        do_reset();
        bitin(1, 0); bitin(0, 0);
        step(0, 1, 1, 0, '0, 0, 0);
        step(0, 0, 0, 0, '0, 0, 0);
        step(0, 1, 1, 0, '0, 0, 0);
        chk("idle_out", int'(out8), 0);
        bitin(1, 0);
        chk("idle_bit3_out", int'(out8), 0);
        bitin(1, 0);
        chk("idle_final_out", int'(out8), 1);

        // pattern load discards old partial and the coincident bit
        do_reset();
        bitin(1, 0); bitin(0, 0); bitin(1, 0);
        step(1, 1, 0, 1, 4'b0110, 0, 0);
        chk("load_out", int'(out8), 0);
        chk("load_cnt", int'(cnt8), 0);
        bitin(0, 0); bitin(1, 0); bitin(1, 0);
        chk("load_bit3_out", int'(out8), 0);
        bitin(0, 0);
        chk("load_bit4_out", int'(out8), 1);

        // all-ones pattern, saturation and clear
        do_reset();
        step(0, 0, 1, 1, 4'b1111, 0, 0);
        for (int i = 0; i < 10; i++) bitin(1, 1);
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_cnt8", int'(cnt8), 7);
        chk("sat_out", int'(out2), 1);
        step(1, 1, 1, 0, '0, 1, 0);
        chk("clr_cnt2", int'(cnt2), 0);
        chk("clr_cnt8", int'(cnt8), 0);
        chk("clr_out", int'(out2), 1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic en, in, ovl, load, clr, rst;
            logic [N-1:0] pat;
            en   = ($urandom_range(0, 3) != 0);
            in   = 1'($urandom_range(0, 1));
            ovl  = ($urandom_range(0, 2) != 0);
            load = ($urandom_range(0, 63) == 0);
            clr  = ($urandom_range(0, 99) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0: pat = 4'b1111;
                1: pat = 4'b1010;
                2: pat = 4'b0000;
                default: pat = 4'($urandom_range(0, 15));
            endcase
            step(en, in, ovl, load, pat, clr, rst);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter N, 4, pattern length in bits; legal range 2..8.
REQ-002 Parameter PATTERN, 4'b1011, N-bit power-up/reset pattern; MSB is the first bit expected.
REQ-003 Parameter CW, 8, match-counter width; legal range 1..16.
REQ-004 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 EN  in  1  bit-valid; IN is consumed only on edges where EN=1.
REQ-007 IN  in  1  serial input bit.
REQ-008 OVL  in  1  mode: 1=overlapping, 0=non-overlapping; sampled on every consumed bit.
REQ-009 LOAD  in  1  pattern-load strobe.
REQ-010 PAT  in  N  new pattern, captured when LOAD=1.
REQ-011 CLR  in  1  synchronous match-counter clear.
REQ-012 OUT  out  1  Moore match flag, registered.
REQ-013 CNT  out  CW  saturating match count, registered.

Function
REQ-014 The block SHALL hold an active pattern register PR[N-1:0] and a progress state k in 0..N, where k is the number of leading pattern bits currently matched.
REQ-015 On a consumed bit b, next k SHALL be the length of the longest prefix of PR that is a suffix of (matched prefix of length k', followed by b), where k'=k if k<N.
REQ-016 If k=N (match state) and OVL=1, k' SHALL be the length of the longest proper prefix of PR that is also a suffix of PR.
REQ-017 If k=N and OVL=0, k' SHALL be 0: the bit after a match starts a fresh search, and no bit of a completed match is reused.
REQ-018 OUT SHALL equal 1 exactly when k=N, i.e. in the cycle after the edge that consumed the final pattern bit, and SHALL depend on state only, never combinationally on IN.
REQ-019 When EN=0, k, OUT and CNT SHALL hold their values; IN and OVL are ignored.
REQ-020 On entering k=N, CNT SHALL increment by 1 and SHALL saturate at 2^CW-1 without wrapping.
REQ-021 CLR=1 SHALL set CNT to 0 on that edge; a simultaneous increment is discarded (CLR wins); k is unaffected.
REQ-022 LOAD=1 SHALL copy PAT into PR, force k=0 and OUT=0 on that edge, and discard any bit presented with EN=1 in the same cycle; CNT is unaffected.
REQ-023 Back-to-back matches (OVL=1, periodic pattern) SHALL keep OUT=1 for consecutive cycles, with CNT incrementing on each one.
REQ-024 An all-zeros or all-ones pattern SHALL be legal; with OVL=1 each additional identical bit after a match SHALL produce a further match.
REQ-025 Border lengths (REQ-016) and prefix-suffix transitions SHALL be computed from PR at run time, not hard-coded for PATTERN.
REQ-026 Latency SHALL be one clock from the consuming edge of the last pattern bit to OUT=1.

Reset
REQ-027 RST=1 SHALL set PR=PATTERN, k=0, OUT=0 and CNT=0 on the next posedge CLK, overriding EN, LOAD and CLR.
REQ-028 A reset asserted mid-sequence SHALL discard all partial progress; no match may complete using bits consumed before the reset.
REQ-029 Outputs SHALL be undefined until the first reset edge; no asynchronous path from RST SHALL exist.

Verification
REQ-030 N=4, PATTERN=1011, OVL=0, EN=1, stream 1,0,1,1,0,1,1 -> OUT=1 only after bit 4; CNT=1.
REQ-031 Same stream with OVL=1 -> OUT=1 after bit 4 and after bit 7; CNT=2.
REQ-032 Stream 1,0,1, then RST for one cycle, then 1 -> OUT stays 0 and CNT=0; the bits 1,0,1,1 following reset -> OUT=1 once.
REQ-033 Bits 1,0 with EN=1, three idle cycles with EN=0 and IN toggling, then 1,1 with EN=1 -> OUT=1 after the final bit; state is held during the idle cycles.
REQ-034 LOAD with PAT=0110 after consuming 1,0,1, then stream 0,1,1,0 -> OUT=1 after the fourth bit; the old partial match is not completed.
REQ-035 CW=2, OVL=1, PAT=1111, 10 consecutive 1s -> CNT reaches 3 and holds; CLR asserted together with the next match -> CNT=0.
